// File: rtl/cla_seq_ctrl.sv
// Sequential adder: one SLICE-bit carry-lookahead group per cycle, NS = WIDTH/SLICE cycles per operation.
// Optional feature macro: CLA_SUB_EN (two's-complement subtract via B inversion and carry-in 1).
module cla_seq_ctrl #(
    parameter int WIDTH = 24,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero,
    output logic             busy
);
    localparam int NS = WIDTH / SLICE;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [KW-1:0]    k_q;
    logic             carry_q, cout_q;
    logic             accept, last_slice;
    logic             carry_load;
    logic [SLICE-1:0] a_sl, b_sl, p, g, s_sl;
    logic [SLICE:0]   c;
    logic             cc, t;

`ifdef CLA_SUB_EN
    logic sub_q;
    assign carry_load = sub;
    assign b_sl       = sub_q ? ~b_q[k_q*SLICE +: SLICE] : b_q[k_q*SLICE +: SLICE];
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign carry_load = 1'b0;
    assign b_sl       = b_q[k_q*SLICE +: SLICE];
`endif

    assign accept     = (state == IDLE) && in_valid && !rst;
    assign last_slice = (k_q == KW'(NS - 1));
    assign a_sl       = a_q[k_q*SLICE +: SLICE];
    assign p          = a_sl ^ b_sl;
    assign g          = a_sl & b_sl;

    // Each carry is a flat sum of products over the generate/propagate terms and the group carry-in.
    always_comb begin
        c  = '0;
        cc = 1'b0;
        t  = 1'b0;
        c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            cc = g[i];
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) t = t & p[m];
                cc = cc | t;
            end
            t = carry_q;
            for (int m = 0; m <= i; m++) t = t & p[m];
            cc = cc | t;
            c[i+1] = cc;
        end
    end

    assign s_sl = p ^ c[SLICE-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef CLA_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            k_q     <= '0;
            carry_q <= carry_load;
`ifdef CLA_SUB_EN
            sub_q   <= sub;
`endif
        end else if (state == RUN) begin
            sum_q[k_q*SLICE +: SLICE] <= s_sl;
            carry_q <= c[SLICE];
            k_q     <= k_q + KW'(1);
            if (last_slice) cout_q <= c[SLICE];
        end
    end

    assign in_ready  = (state == IDLE) || rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign zero      = rst || (sum_q == '0);
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Directed bench for cla_seq_ctrl at WIDTH=24, SLICE=4; expectations follow CLA_SUB_EN when defined.
module tb_cla_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] sum;
    logic        cout, zero, busy;

    int errors = 0;
    int checks = 0;

    cla_seq_ctrl #(.WIDTH(24), .SLICE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 24'h000005; b = 24'h000005; sub = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || zero !== 1'b1) begin
            errors++; $display("FAIL reset_comb: in_ready=%b zero=%b, want 1 1", in_ready, zero);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 24'h0 || cout !== 1'b0) begin
            errors++; $display("FAIL reset_state: busy=%b out_valid=%b sum=%h cout=%b, want 0 0 000000 0",
                               busy, out_valid, sum, cout);
        end
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: busy=%b in_ready=%b, want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_ops();
        logic [23:0] ta[5], tb_v[5], ts[5];
        logic        tsub[5], tc[5], tz[5];
        int          lat;
        ta[0] = 24'h000001; tb_v[0] = 24'h000001; tsub[0] = 0; ts[0] = 24'h000002; tc[0] = 0; tz[0] = 0;
        ta[1] = 24'hFFFFFF; tb_v[1] = 24'h000001; tsub[1] = 0; ts[1] = 24'h000000; tc[1] = 1; tz[1] = 1;
`ifdef CLA_SUB_EN
        ta[2] = 24'h000005; tb_v[2] = 24'h000007; tsub[2] = 1; ts[2] = 24'hFFFFFE; tc[2] = 0; tz[2] = 0;
        ta[3] = 24'h000007; tb_v[3] = 24'h000005; tsub[3] = 1; ts[3] = 24'h000002; tc[3] = 1; tz[3] = 0;
`else
        ta[2] = 24'h000005; tb_v[2] = 24'h000007; tsub[2] = 1; ts[2] = 24'h00000C; tc[2] = 0; tz[2] = 0;
        ta[3] = 24'h000007; tb_v[3] = 24'h000005; tsub[3] = 1; ts[3] = 24'h00000C; tc[3] = 0; tz[3] = 0;
`endif
        ta[4] = 24'h123456; tb_v[4] = 24'h654321; tsub[4] = 0; ts[4] = 24'h777777; tc[4] = 0; tz[4] = 0;
        for (int i = 0; i < 5; i++) begin
            a = ta[i]; b = tb_v[i]; sub = tsub[i]; in_valid = 1'b1; out_ready = 1'b0;
            #0;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL ops_ready[%0d]: in_ready=%b, want 1", i, in_ready);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL ops_busy[%0d]: busy=%b in_ready=%b, want 1 0", i, busy, in_ready);
            end
            lat = 0;
            do begin
                @(posedge clk); #1; lat++;
            end while (!out_valid && lat < 20);
            checks++;
            if (lat !== 6) begin
                errors++; $display("FAIL ops_latency[%0d]: edges=%0d, want 6", i, lat);
            end
            checks++;
            if (sum !== ts[i] || cout !== tc[i] || zero !== tz[i]) begin
                errors++; $display("FAIL ops_result[%0d]: sum=%h cout=%b zero=%b, want %h %b %b",
                                   i, sum, cout, zero, ts[i], tc[i], tz[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL ops_release[%0d]: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
                                   i, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        a = 24'h000123; b = 24'h000456; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            a = 24'hFFFFFF; b = 24'hFFFFFF; sub = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (lat !== 6 || sum !== 24'h000579 || cout !== 1'b0) begin
            errors++; $display("FAIL hold_capture: edges=%0d sum=%h cout=%b, want 6 000579 0", lat, sum, cout);
        end
        for (int i = 0; i < 10; i++) begin
            a = 24'($urandom); b = 24'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 24'h000579 || cout !== 1'b0) begin
                errors++; $display("FAIL hold_stable[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b, want 1 0 000579 0",
                                   i, out_valid, in_ready, sum, cout);
            end
        end
        in_valid = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        a = 24'h111111; b = 24'h222222; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (zero !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_comb: zero=%b in_ready=%b, want 1 1", zero, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 24'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_state: in_ready=%b out_valid=%b sum=%h busy=%b, want 1 0 000000 0",
                               in_ready, out_valid, sum, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL abort_no_result[%0d]: out_valid=%b, want 0", i, out_valid);
            end
        end
        a = 24'h000010; b = 24'h000020; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!out_valid && lat < 20);
        checks++;
        if (lat !== 6 || sum !== 24'h000030 || cout !== 1'b0) begin
            errors++; $display("FAIL abort_next_op: edges=%0d sum=%h cout=%b, want 6 000030 0", lat, sum, cout);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [23:0] va[4], vb[4], vs[4];
        logic        vc[4];
        int          acc[4];
        int          n, r;
        va[0] = 24'h000001; vb[0] = 24'h000002; vs[0] = 24'h000003; vc[0] = 0;
        va[1] = 24'h0F0F0F; vb[1] = 24'h010101; vs[1] = 24'h101010; vc[1] = 0;
        va[2] = 24'h800000; vb[2] = 24'h800000; vs[2] = 24'h000000; vc[2] = 1;
        va[3] = 24'hABCDEF; vb[3] = 24'h123456; vs[3] = 24'hBE0245; vc[3] = 0;
        n = 0; r = 0;
        a = va[0]; b = vb[0]; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && r < 4; cyc++) begin
            if (out_valid) begin
                checks++;
                if (sum !== vs[r] || cout !== vc[r]) begin
                    errors++; $display("FAIL b2b_result[%0d]: sum=%h cout=%b, want %h %b", r, sum, cout, vs[r], vc[r]);
                end
                r++;
            end
            if (in_ready && in_valid && n < 4) begin
                acc[n] = cyc; n++;
            end
            @(posedge clk); #1;
            if (n < 4) begin
                a = va[n]; b = vb[n];
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (r !== 4 || n !== 4) begin
            errors++; $display("FAIL b2b_count: results=%0d accepts=%0d, want 4 4", r, n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc[i+1] - acc[i] !== 8) begin
                    errors++; $display("FAIL b2b_interval[%0d]: cycles=%0d, want 8", i, acc[i+1] - acc[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
